// File: rtl/weight_bias_merge_pkg.sv
// Shared definitions for the weight/bias merge and separator pair.
// Holds the state encodings, the default beat-size shifts and the PS source tag.
// Both blocks import this package, so the two config words frame a transfer the same way in each block.
package weight_bias_merge_pkg;

    // Config word0 bit 31 carries the source tag; only PS-sourced transfers move data.
    localparam logic PS = 1'b1;

    // Bytes-to-beats conversion applied to the two config words.
    localparam int BIAS_SHIFT_DEF   = 2;
    localparam int WEIGHT_SHIFT_DEF = 3;

    typedef enum logic [1:0] {
        WBM_CFG0   = 2'd0,
        WBM_CFG1   = 2'd1,
        WBM_BIAS   = 2'd2,
        WBM_WEIGHT = 2'd3
    } wbm_state_t;

endpackage

// File: rtl/weight_bias_merge_axis_out_reg.sv
// Single-entry registered AXI-Stream slice (data, valid, last); reusable for the separator outputs.
// Latency: 1 cycle from an accepted input beat to out_vld.
// Backpressure: load_en = ~out_vld | out_rdy; a stalled beat holds data/valid/last until taken.
// Ports: clk/rst; in_vld/in_dat/in_last are loaded when load_en is high;
//        out_vld/out_rdy/out_dat/out_last form the downstream stream.
module weight_bias_merge_axis_out_reg #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_last,
    output logic              load_en,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_last
);

    assign load_en = ~out_vld | out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else if (load_en) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat  <= in_dat;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/weight_bias_merge.sv
// Merges a bias stream then a weight stream into one AXI-Stream, sized by a two-word config header.
// Latency: 1 cycle from an input handshake to m_axis_wb_tvalid; 1 beat/cycle when downstream is ready.
// Backpressure: input tready follows the output slice's load enable; stalled beats are held stable.
// Ports: s_axis_wbconfig_* (word0 = {source, bias_size}, word1 = weight_size), s_axis_bias_*,
//        s_axis_weight_*, m_axis_wb_* (merged output with tlast), status_wbm = {2'b00, state}.
module weight_bias_merge
    import weight_bias_merge_pkg::*;
#(
    parameter int DATA_W       = 128,
    parameter int CFG_W        = 32,
    parameter int BIAS_SHIFT   = BIAS_SHIFT_DEF,
    parameter int WEIGHT_SHIFT = WEIGHT_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_wbconfig_tvalid,
    output logic              s_axis_wbconfig_tready,
    input  logic [CFG_W-1:0]  s_axis_wbconfig_tdata,
    input  logic              s_axis_bias_tvalid,
    output logic              s_axis_bias_tready,
    input  logic [DATA_W-1:0] s_axis_bias_tdata,
    input  logic              s_axis_weight_tvalid,
    output logic              s_axis_weight_tready,
    input  logic [DATA_W-1:0] s_axis_weight_tdata,
    output logic              m_axis_wb_tvalid,
    input  logic              m_axis_wb_tready,
    output logic [DATA_W-1:0] m_axis_wb_tdata,
    output logic              m_axis_wb_tlast,
    output logic [3:0]        status_wbm
);

    wbm_state_t        cs, ns;
    logic              src;
    logic [CFG_W-2:0]  bias_beats;
    logic [CFG_W-1:0]  weight_beats;
    logic [CFG_W-1:0]  cnt;
    logic [CFG_W-1:0]  cnt_inc;
    logic [CFG_W-1:0]  cfg_weight_beats;

    logic              load_en;
    logic              cfg_hs, bias_hs, weight_hs;
    logic              bias_done, weight_done;
    logic              beat_vld, beat_last;
    logic [DATA_W-1:0] beat_dat;

    assign s_axis_wbconfig_tready = ~rst & ((cs == WBM_CFG0) | (cs == WBM_CFG1));
    assign s_axis_bias_tready     = ~rst & load_en & (cs == WBM_BIAS);
    assign s_axis_weight_tready   = ~rst & load_en & (cs == WBM_WEIGHT);

    assign cfg_hs    = s_axis_wbconfig_tvalid & s_axis_wbconfig_tready;
    assign bias_hs   = s_axis_bias_tvalid & s_axis_bias_tready;
    assign weight_hs = s_axis_weight_tvalid & s_axis_weight_tready;

    assign cnt_inc          = cnt + 1'b1;
    assign bias_done        = (cnt_inc == {1'b0, bias_beats});
    assign weight_done      = (cnt_inc == weight_beats);
    assign cfg_weight_beats = s_axis_wbconfig_tdata >> WEIGHT_SHIFT;

    // The last bias beat closes the transfer only when no weight beats follow.
    assign beat_vld  = bias_hs | weight_hs;
    assign beat_dat  = bias_hs ? s_axis_bias_tdata : s_axis_weight_tdata;
    assign beat_last = bias_hs ? (bias_done & (weight_beats == '0)) : weight_done;

    always_comb begin
        ns = cs;
        case (cs)
            WBM_CFG0: begin
                if (cfg_hs) ns = WBM_CFG1;
            end
            WBM_CFG1: begin
                // Decide on the incoming word1 directly so no idle cycle is spent in CFG1.
                if (cfg_hs) begin
                    if (src != PS)                ns = WBM_CFG0;
                    else if (bias_beats != '0)    ns = WBM_BIAS;
                    else if (cfg_weight_beats != '0) ns = WBM_WEIGHT;
                    else                          ns = WBM_CFG0;
                end
            end
            WBM_BIAS: begin
                if (bias_hs && bias_done)
                    ns = (weight_beats != '0) ? WBM_WEIGHT : WBM_CFG0;
            end
            WBM_WEIGHT: begin
                if (weight_hs && weight_done) ns = WBM_CFG0;
            end
            default: ns = WBM_CFG0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs           <= WBM_CFG0;
            src          <= 1'b0;
            bias_beats   <= '0;
            weight_beats <= '0;
            cnt          <= '0;
        end else begin
            cs <= ns;
            if (cfg_hs && cs == WBM_CFG0) begin
                src        <= s_axis_wbconfig_tdata[CFG_W-1];
                bias_beats <= s_axis_wbconfig_tdata[CFG_W-2:0] >> BIAS_SHIFT;
            end
            if (cfg_hs && cs == WBM_CFG1)
                weight_beats <= cfg_weight_beats;
            if (bias_hs)
                cnt <= bias_done ? '0 : cnt_inc;
            else if (weight_hs)
                cnt <= weight_done ? '0 : cnt_inc;
        end
    end

    weight_bias_merge_axis_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (beat_vld),
        .in_dat   (beat_dat),
        .in_last  (beat_last),
        .load_en  (load_en),
        .out_vld  (m_axis_wb_tvalid),
        .out_rdy  (m_axis_wb_tready),
        .out_dat  (m_axis_wb_tdata),
        .out_last (m_axis_wb_tlast)
    );

    assign status_wbm = {2'b00, cs};

endmodule

// File: tb/tb_weight_bias_merge.sv
module tb_weight_bias_merge;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_vld, cfg_rdy;
    logic [31:0]  cfg_dat;
    logic         bias_vld, bias_rdy;
    logic [127:0] bias_dat;
    logic         weight_vld, weight_rdy;
    logic [127:0] weight_dat;
    logic         m_vld, m_rdy, m_last;
    logic [127:0] m_dat;
    logic [3:0]   status;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    weight_bias_merge dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_wbconfig_tvalid (cfg_vld),
        .s_axis_wbconfig_tready (cfg_rdy),
        .s_axis_wbconfig_tdata  (cfg_dat),
        .s_axis_bias_tvalid     (bias_vld),
        .s_axis_bias_tready     (bias_rdy),
        .s_axis_bias_tdata      (bias_dat),
        .s_axis_weight_tvalid   (weight_vld),
        .s_axis_weight_tready   (weight_rdy),
        .s_axis_weight_tdata    (weight_dat),
        .m_axis_wb_tvalid       (m_vld),
        .m_axis_wb_tready       (m_rdy),
        .m_axis_wb_tdata        (m_dat),
        .m_axis_wb_tlast        (m_last),
        .status_wbm             (status)
    );

    // Source queues drained by the feeder; output beats captured by the monitor.
    logic [31:0]  cfg_q[$];
    logic [127:0] bias_q[$];
    logic [127:0] weight_q[$];
    logic [127:0] out_dat_q[$];
    logic         out_last_q[$];

    int  m_mode    = 2;   // 0: ready high, 1: toggle, 2: ready low
    bit  rand_vld  = 0;
    int  cyc       = 0;
    int  first_in_cyc, first_out_cyc, last_out_cyc;
    int  stall_err;
    bit  bias_rdy_seen, in_rdy_seen;
    bit  prev_stall;
    logic [127:0] prev_dat;
    logic         prev_last;

    always begin
        bit b_hs, w_hs, c_hs, m_hs;
        logic [127:0] dummy_d;
        logic [31:0]  dummy_c;
        @(negedge clk);
        cyc++;
        b_hs = bias_vld && bias_rdy;
        w_hs = weight_vld && weight_rdy;
        c_hs = cfg_vld && cfg_rdy;
        m_hs = m_vld && m_rdy;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (m_vld !== 1'b1 || m_dat !== prev_dat || m_last !== prev_last))
                stall_err++;
            prev_stall = m_vld && !m_rdy;
            prev_dat   = m_dat;
            prev_last  = m_last;
            if (bias_rdy) bias_rdy_seen = 1;
            if (bias_rdy || weight_rdy) in_rdy_seen = 1;
            if ((b_hs || w_hs) && first_in_cyc < 0) first_in_cyc = cyc;
            if (m_vld && first_out_cyc < 0) first_out_cyc = cyc;
            if (m_hs) begin
                out_dat_q.push_back(m_dat);
                out_last_q.push_back(m_last);
                last_out_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        if (b_hs && bias_q.size() > 0)   dummy_d = bias_q.pop_front();
        if (w_hs && weight_q.size() > 0) dummy_d = weight_q.pop_front();
        if (c_hs && cfg_q.size() > 0)    dummy_c = cfg_q.pop_front();
        bias_vld   = (bias_q.size() > 0) && (!rand_vld || $urandom_range(0, 1) == 1);
        bias_dat   = (bias_q.size() > 0) ? bias_q[0] : '0;
        weight_vld = (weight_q.size() > 0) && (!rand_vld || $urandom_range(0, 1) == 1);
        weight_dat = (weight_q.size() > 0) ? weight_q[0] : '0;
        cfg_vld    = cfg_q.size() > 0;
        cfg_dat    = (cfg_q.size() > 0) ? cfg_q[0] : '0;
        case (m_mode)
            0:       m_rdy = 1'b1;
            1:       m_rdy = ~m_rdy;
            default: m_rdy = 1'b0;
        endcase
    end

    function automatic logic [127:0] bpat(input int i);
        logic [31:0] w;
        w = 32'hB1A5_0000 + i;
        return {4{w}};
    endfunction

    function automatic logic [127:0] wpat(input int i);
        logic [31:0] w;
        w = 32'hE1E1_0000 + i;
        return {4{w}};
    endfunction

    task automatic start_case();
        @(posedge clk);
        #2;
        out_dat_q.delete();
        out_last_q.delete();
        first_in_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
        stall_err     = 0;
        bias_rdy_seen = 0;
        in_rdy_seen   = 0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && out_dat_q.size() < n; i++) @(posedge clk);
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (m_vld !== 1'b0)   begin miscompares++; $display("FAIL reset_tvalid got %b want 0", m_vld); end
        vectors++; if (m_last !== 1'b0)  begin miscompares++; $display("FAIL reset_tlast got %b want 0", m_last); end
        vectors++; if (m_dat !== '0)     begin miscompares++; $display("FAIL reset_tdata got %h want 0", m_dat); end
        vectors++; if (status !== 4'd0)  begin miscompares++; $display("FAIL reset_status got %0d want 0", status); end
        vectors++; if (cfg_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_rdy got %b want 0", cfg_rdy); end
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        vectors++; if (cfg_rdy !== 1'b1) begin miscompares++; $display("FAIL idle_cfg_rdy got %b want 1", cfg_rdy); end
    endtask

    task automatic test_basic();
        start_case();
        m_mode = 0;
        rand_vld = 0;
        for (int i = 0; i < 4; i++) begin bias_q.push_back(bpat(i)); weight_q.push_back(wpat(i)); end
        cfg_q.push_back(32'h8000_0010);
        cfg_q.push_back(32'd32);
        wait_beats(8, 200);
        vectors++; if (out_dat_q.size() !== 8) begin miscompares++; $display("FAIL basic_count got %0d want 8", out_dat_q.size()); end
        for (int k = 0; k < out_dat_q.size() && k < 8; k++) begin
            vectors++;
            if (out_dat_q[k] !== (k < 4 ? bpat(k) : wpat(k - 4)) || out_last_q[k] !== (k == 7)) begin
                miscompares++;
                $display("FAIL basic_beat%0d got %h/%b want %h/%b", k, out_dat_q[k], out_last_q[k],
                         (k < 4 ? bpat(k) : wpat(k - 4)), (k == 7));
            end
        end
        vectors++; if (first_out_cyc - first_in_cyc !== 1) begin miscompares++; $display("FAIL basic_latency got %0d want 1", first_out_cyc - first_in_cyc); end
        vectors++; if (last_out_cyc - first_out_cyc !== 7) begin miscompares++; $display("FAIL basic_contiguous got %0d want 7", last_out_cyc - first_out_cyc); end
        vectors++; if (status !== 4'd0) begin miscompares++; $display("FAIL basic_end_status got %0d want 0", status); end
    endtask

    task automatic test_backpressure();
        start_case();
        m_mode = 1;
        rand_vld = 1;
        for (int i = 0; i < 4; i++) begin bias_q.push_back(bpat(i + 8)); weight_q.push_back(wpat(i + 8)); end
        cfg_q.push_back(32'h8000_0010);
        cfg_q.push_back(32'd32);
        wait_beats(8, 400);
        repeat (10) @(posedge clk);
        vectors++; if (out_dat_q.size() !== 8) begin miscompares++; $display("FAIL bp_count got %0d want 8", out_dat_q.size()); end
        for (int k = 0; k < out_dat_q.size() && k < 8; k++) begin
            vectors++;
            if (out_dat_q[k] !== (k < 4 ? bpat(k + 8) : wpat(k + 4)) || out_last_q[k] !== (k == 7)) begin
                miscompares++;
                $display("FAIL bp_beat%0d got %h/%b", k, out_dat_q[k], out_last_q[k]);
            end
        end
        vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); end
        m_mode = 0;
        rand_vld = 0;
    endtask

    task automatic test_zero_sizes();
        start_case();
        for (int i = 0; i < 2; i++) weight_q.push_back(wpat(i + 16));
        bias_q.push_back(bpat(99));
        cfg_q.push_back(32'h8000_0000);
        cfg_q.push_back(32'd16);
        wait_beats(2, 100);
        vectors++; if (out_dat_q.size() !== 2) begin miscompares++; $display("FAIL zb_count got %0d want 2", out_dat_q.size()); end
        for (int k = 0; k < out_dat_q.size() && k < 2; k++) begin
            vectors++;
            if (out_dat_q[k] !== wpat(k + 16) || out_last_q[k] !== (k == 1)) begin
                miscompares++;
                $display("FAIL zb_beat%0d got %h/%b", k, out_dat_q[k], out_last_q[k]);
            end
        end
        vectors++; if (bias_rdy_seen !== 1'b0) begin miscompares++; $display("FAIL zb_bias_rdy got %b want 0", bias_rdy_seen); end

        // The leftover bias beat above is consumed as the first of two bias-only beats.
        start_case();
        bias_q.push_back(bpat(100));
        cfg_q.push_back(32'h8000_0008);
        cfg_q.push_back(32'd0);
        wait_beats(2, 100);
        vectors++; if (out_dat_q.size() !== 2) begin miscompares++; $display("FAIL zw_count got %0d want 2", out_dat_q.size()); end
        for (int k = 0; k < out_dat_q.size() && k < 2; k++) begin
            vectors++;
            if (out_dat_q[k] !== bpat(k + 99) || out_last_q[k] !== (k == 1)) begin
                miscompares++;
                $display("FAIL zw_beat%0d got %h/%b", k, out_dat_q[k], out_last_q[k]);
            end
        end
    endtask

    task automatic test_non_ps();
        start_case();
        bias_q.push_back(bpat(50));
        weight_q.push_back(wpat(50));
        cfg_q.push_back(32'h0000_0010);
        cfg_q.push_back(32'd32);
        repeat (20) @(posedge clk);
        vectors++; if (cfg_q.size() !== 0) begin miscompares++; $display("FAIL nps_cfg_left got %0d want 0", cfg_q.size()); end
        vectors++; if (status !== 4'd0) begin miscompares++; $display("FAIL nps_status got %0d want 0", status); end
        vectors++; if (in_rdy_seen !== 1'b0) begin miscompares++; $display("FAIL nps_in_rdy got %b want 0", in_rdy_seen); end
        vectors++; if (out_dat_q.size() !== 0) begin miscompares++; $display("FAIL nps_beats got %0d want 0", out_dat_q.size()); end
        bias_q.delete();
        weight_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        start_case();
        m_mode = 0;
        for (int i = 0; i < 4; i++) begin bias_q.push_back(bpat(i + 60)); weight_q.push_back(wpat(i + 60)); end
        cfg_q.push_back(32'h8000_0010);
        cfg_q.push_back(32'd32);
        for (int i = 0; i < 100 && out_dat_q.size() < 2; i++) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (m_vld !== 1'b0)  begin miscompares++; $display("FAIL rmid_tvalid got %b want 0", m_vld); end
        vectors++; if (status !== 4'd0) begin miscompares++; $display("FAIL rmid_status got %0d want 0", status); end
        bias_q.delete();
        weight_q.delete();
        cfg_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        start_case();
        bias_q.push_back(bpat(70));
        weight_q.push_back(wpat(70));
        cfg_q.push_back(32'h8000_0004);
        cfg_q.push_back(32'd8);
        wait_beats(2, 100);
        vectors++; if (out_dat_q.size() !== 2) begin miscompares++; $display("FAIL rmid_count got %0d want 2", out_dat_q.size()); end
        for (int k = 0; k < out_dat_q.size() && k < 2; k++) begin
            vectors++;
            if (out_dat_q[k] !== (k == 0 ? bpat(70) : wpat(70)) || out_last_q[k] !== (k == 1)) begin
                miscompares++;
                $display("FAIL rmid_beat%0d got %h/%b", k, out_dat_q[k], out_last_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        start_case();
        m_mode = 2;
        bias_q.push_back(bpat(80));
        bias_q.push_back(bpat(81));
        bias_q.push_back(bpat(82));
        weight_q.push_back(wpat(81));
        cfg_q.push_back(32'h8000_0004);
        cfg_q.push_back(32'd0);
        cfg_q.push_back(32'h8000_0008);
        cfg_q.push_back(32'd8);
        repeat (15) @(posedge clk);
        @(negedge clk);
        vectors++; if (cfg_q.size() !== 0) begin miscompares++; $display("FAIL b2b_cfg_left got %0d want 0", cfg_q.size()); end
        vectors++; if (m_vld !== 1'b1 || m_last !== 1'b1 || m_dat !== bpat(80)) begin
            miscompares++;
            $display("FAIL b2b_held got %b/%b/%h want 1/1/%h", m_vld, m_last, m_dat, bpat(80));
        end
        vectors++; if (status !== 4'd2) begin miscompares++; $display("FAIL b2b_status got %0d want 2", status); end
        @(posedge clk);
        #2 m_mode = 0;
        wait_beats(4, 100);
        vectors++; if (out_dat_q.size() !== 4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", out_dat_q.size()); end
        for (int k = 0; k < out_dat_q.size() && k < 4; k++) begin
            vectors++;
            if (out_dat_q[k] !== (k < 3 ? bpat(k + 80) : wpat(81)) || out_last_q[k] !== (k == 0 || k == 3)) begin
                miscompares++;
                $display("FAIL b2b_beat%0d got %h/%b", k, out_dat_q[k], out_last_q[k]);
            end
        end
        vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL b2b_stall_stable got %0d changes want 0", stall_err); end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_vld    = 1'b0;
        cfg_dat    = '0;
        bias_vld   = 1'b0;
        bias_dat   = '0;
        weight_vld = 1'b0;
        weight_dat = '0;
        m_rdy      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_sizes();
        test_non_ps();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
